// File: rtl/present_core.sv
// present_core: iterative PRESENT block cipher (64-bit block, 80- or 128-bit key).
// UNROLL rounds are evaluated per clock on one shared round and key-schedule datapath.
// Only one block is in flight at a time. in_ready stays low until the result has been taken.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_key (KEY_W bits) and in_data (64 bits)
//   out_valid/out_ready   result handshake; out_data (64 bits) is held while out_valid=1
//   in_dec                exists only when PRESENT_DEC_EN is defined; 1 selects decryption
// Latency is ROUNDS/UNROLL cycles from the accept edge to out_valid.
// Decryption latency is 2*ROUNDS/UNROLL+1 cycles.
// Optional feature macro: PRESENT_DEC_EN. It adds in_dec and the inverse datapath.
module present_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic [63:0]      in_data,
`ifdef PRESENT_DEC_EN
  input  logic             in_dec,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("present_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_core: ROUNDS must be in 1..31");
  end
  if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
    $error("present_core: UNROLL must divide ROUNDS");
  end

  // LSB of the 5-bit key field that absorbs the round counter
  localparam int XB = (KEY_W == 128) ? 62 : 15;
  // S-box as a nibble table: entry x sits at bits [4x+3:4x]
  localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_DONE, ST_KFWD, ST_KXOR, ST_RUN_INV
  } state_t;

  function automatic logic [3:0] sb(input logic [3:0] x);
    return SBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] v;
    for (int n = 0; n < 16; n++) v[4*n +: 4] = sb(s[4*n +: 4]);
    return v;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] v;
    v[63] = s[63];
    for (int j = 0; j < 63; j++) v[(16*j) % 63] = s[j];
    return v;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] v;
    v = (k << 61) | (k >> (KEY_W - 61));
    v[KEY_W-1 -: 4] = sb(v[KEY_W-1 -: 4]);
    if (KEY_W == 128) v[KEY_W-5 -: 4] = sb(v[KEY_W-5 -: 4]);
    v[XB +: 5] = v[XB +: 5] ^ rc;
    return v;
  endfunction

  state_t           r_state, w_state_nxt;
  logic             r_live;    // low in reset and until the first clock edge after release
  logic [63:0]      r_s, r_out;
  logic [KEY_W-1:0] r_k;
  logic [4:0]       r_rc;
  logic             w_acc, w_fwd_last;

  // Forward round chain: UNROLL rounds starting from the registered state
  logic [63:0]      w_s [0:UNROLL];
  logic [KEY_W-1:0] w_k [0:UNROLL];
  assign w_s[0] = r_s;
  assign w_k[0] = r_k;
  for (genvar g = 0; g < UNROLL; g++) begin : g_fwd
    assign w_s[g+1] = p_layer(sbox_layer(w_s[g] ^ w_k[g][KEY_W-1 -: 64]));
    assign w_k[g+1] = key_fwd(w_k[g], r_rc + 5'(g));
  end
  // The counter stops at the final round, so ROUNDS=31 never wraps the 5-bit counter
  assign w_fwd_last = (int'(r_rc) + UNROLL - 1 == ROUNDS);

`ifdef PRESENT_DEC_EN
  localparam logic [63:0] ISBOX_TAB = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] isb(input logic [3:0] x);
    return ISBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] v;
    for (int n = 0; n < 16; n++) v[4*n +: 4] = isb(s[4*n +: 4]);
    return v;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] v;
    v[63] = s[63];
    for (int j = 0; j < 63; j++) v[j] = s[(16*j) % 63];
    return v;
  endfunction

  // Undo key_fwd step by step in reverse order
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] v;
    v = k;
    v[XB +: 5] = v[XB +: 5] ^ rc;
    v[KEY_W-1 -: 4] = isb(v[KEY_W-1 -: 4]);
    if (KEY_W == 128) v[KEY_W-5 -: 4] = isb(v[KEY_W-5 -: 4]);
    return (v >> 61) | (v << (KEY_W - 61));
  endfunction

  // Inverse chain: the counter runs downward from r_rc
  logic [63:0]      w_is [0:UNROLL];
  logic [KEY_W-1:0] w_ik [0:UNROLL];
  logic             w_inv_last;
  assign w_is[0] = r_s;
  assign w_ik[0] = r_k;
  for (genvar g = 0; g < UNROLL; g++) begin : g_inv
    assign w_ik[g+1] = key_inv(w_ik[g], r_rc - 5'(g));
    assign w_is[g+1] = inv_sbox_layer(inv_p_layer(w_is[g])) ^ w_ik[g+1][KEY_W-1 -: 64];
  end
  assign w_inv_last = (r_rc == 5'(UNROLL));
`endif

  assign in_ready  = r_live && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_out;
  assign w_acc     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
`ifdef PRESENT_DEC_EN
          w_state_nxt = in_dec ? ST_KFWD : ST_RUN;
`else
          w_state_nxt = ST_RUN;
`endif
        end
      end
      ST_RUN:     if (w_fwd_last) w_state_nxt = ST_DONE;
      ST_DONE:    if (out_ready)  w_state_nxt = ST_IDLE;
`ifdef PRESENT_DEC_EN
      ST_KFWD:    if (w_fwd_last) w_state_nxt = ST_KXOR;
      ST_KXOR:    w_state_nxt = ST_RUN_INV;
      ST_RUN_INV: if (w_inv_last) w_state_nxt = ST_DONE;
`endif
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_s    <= '0;
      r_k    <= '0;
      r_rc   <= '0;
      r_out  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_s  <= in_data;
            r_k  <= in_key;
            r_rc <= 5'd1;
          end
        end
        ST_RUN: begin
          r_s <= w_s[UNROLL];
          r_k <= w_k[UNROLL];
          if (w_fwd_last) r_out <= w_s[UNROLL] ^ w_k[UNROLL][KEY_W-1 -: 64];
          else            r_rc  <= r_rc + 5'(UNROLL);
        end
`ifdef PRESENT_DEC_EN
        ST_KFWD: begin
          // Walk the schedule forward to the last round key; the block is untouched
          r_k <= w_k[UNROLL];
          if (w_fwd_last) r_rc <= 5'(ROUNDS);
          else            r_rc <= r_rc + 5'(UNROLL);
        end
        ST_KXOR: r_s <= r_s ^ r_k[KEY_W-1 -: 64];
        ST_RUN_INV: begin
          r_s <= w_is[UNROLL];
          r_k <= w_ik[UNROLL];
          if (w_inv_last) r_out <= w_is[UNROLL];
          else            r_rc  <= r_rc - 5'(UNROLL);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/present_core.md
Name: present_core

Overview:
- Iterative, handshaked PRESENT block-cipher engine: 64-bit block, 80- or 128-bit key.
- Computes UNROLL rounds per clock and reuses one round/key-schedule datapath for ROUNDS rounds.
- Sits between a valid/ready message source and a valid/ready ciphertext sink.
- Replaces the fully unrolled fixed-80-bit encryptor: one block in flight, far less area, selectable key width and throughput.

Parameters:
- KEY_W, 80, key width; legal values 80 or 128; any other value is an elaboration error.
- ROUNDS, 31, number of rounds; legal range 1..31.
- UNROLL, 1, rounds per clock; must divide ROUNDS; otherwise elaboration error.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- in_key  input  KEY_W  key.
- in_data  input  64  plaintext (ciphertext when decrypting).
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- out_data  output  64  result.

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0:
  - FSM=IDLE; state, key and counter registers=0.
  - in_ready=0 during reset, 1 from the first posedge after release.
  - out_valid=0; out_data=0.
- Reset mid-operation aborts the block; no result is produced.
- FSM states:
  - IDLE: in_ready=1. A transfer (in_valid and in_ready at posedge) loads S=in_data, K=in_key, rc=1, then goes to RUN.
  - RUN: in_ready=0. Each cycle applies UNROLL rounds with counters rc..rc+UNROLL-1, then rc+=UNROLL. After round ROUNDS it registers out_data=S^K[KEY_W-1:KEY_W-64] and goes to DONE.
  - DONE: out_valid=1 and out_data are held stable until out_ready=1 at a posedge, then return to IDLE.
- out_valid and in_ready are never both 1. Requests arriving during RUN or DONE are back-pressured, not dropped.
- Latency: ROUNDS/UNROLL cycles from the accept edge to out_valid. Throughput: one block per ROUNDS/UNROLL+2 cycles with out_ready held high.
- Round i:
  - S ^= K[KEY_W-1:KEY_W-64].
  - Apply the 4-bit S-box to all 16 nibbles: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - pLayer: bit j moves to (16*j mod 63) for j<63; bit 63 is fixed.
- Key update, round i:
  - KEY_W=80: rotate left 61; S-box K[79:76]; K[19:15]^=i[4:0].
  - KEY_W=128: rotate left 61; S-box K[127:124] and K[123:120]; K[66:62]^=i[4:0].
- Round counter is 5 bits; ROUNDS=31 ends at rc=31 without wrapping.
- A reset edge coinciding with an accept edge wins: nothing is loaded.

Optional Feature:
- Macro: PRESENT_DEC_EN.
- When defined, adds input in_dec (1 bit), sampled at accept.
- in_dec=0: encryption exactly as above.
- in_dec=1 runs three phases:
  - KEYFWD: ROUNDS/UNROLL cycles of forward key updates only; S is held.
  - Then S^=K.
  - RUN_INV: for i=ROUNDS down to 1, apply inverse key update with counter i, then S=invSbox(invP(S))^K[top 64]. UNROLL rounds per cycle.
  - Result goes to DONE.
- Decrypt latency: 2*ROUNDS/UNROLL+1 cycles.
- When not defined: no in_dec port; encrypt only; no inverse S-box/pLayer logic is synthesised.

Test Plan:
- KEY_W=80, key=0, pt=0 -> out_data=5579C1387B228445 after 31 cycles (UNROLL=1); in_ready low throughout.
- KEY_W=80, key=FFFF_FFFF_FFFF_FFFF_FFFF, pt=FFFFFFFFFFFFFFFF -> 3333DCD3213210D2. Repeat with UNROLL=31 -> same value after 1 cycle.
- KEY_W=128, key=0, pt=0 -> 96DB702A2E6900AF.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> IDLE next cycle and the second block is accepted.
- Drop rst_n at RUN cycle 15 -> out_valid=0 immediately. After release, a new block pt=0, key=FFFF... (80-bit) -> E72C46C0F5945049 with no corruption from the aborted block.
- With PRESENT_DEC_EN: in_dec=1, ct=5579C1387B228445, key=0 -> 0000000000000000 after 63 cycles. Random encrypt/decrypt round-trip over 1000 vectors -> identity.
